// File: rtl/dm_access_port.sv
// Data-SRAM access port: turns MEM-stage loads/stores into SRAM cycles,
// splitting misaligned accesses into two word cycles and merging load data.
module dm_access_port #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              DM_CEB,
    output logic              DM_WEB,
    output logic [31:0]       DM_BWEB,
    output logic [ADDR_W-1:0] DM_A,
    output logic [31:0]       DM_DI,
    input  logic [31:0]       DM_DO
);
    typedef enum logic {S_IDLE, S_SECOND} state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        w_off, w_size;
    logic [ADDR_W-1:0] w_word;
    logic              w_mis;
    logic [7:0]        w_size_mask, w_mask;
    logic [3:0]        w_lanes;
    logic [5:0]        w_sh_lo, w_sh_hi;
    logic              w_rd_issue, w_rsp_fire;
    logic [63:0]       w_merge;
    logic [31:0]       w_shifted, w_ext;
    logic              w_unused;

    logic              r_rd_vld, r_rd_uns, r_rd_split, r_rd_half;
    logic [1:0]        r_rd_off, r_rd_size;
    logic [31:0]       r_lo_hold;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;

    assign w_off    = req_addr[1:0];
    assign w_size   = req_funct3[1:0];
    assign w_word   = req_addr[ADDR_W+1:2];
    assign w_unused = &{1'b0, req_addr[31:ADDR_W+2]};
    assign w_mis    = (w_size == 2'b01 && w_off == 2'b11) || (w_size[1] && w_off != 2'b00);
    assign w_mask   = w_size_mask << w_off;
    assign w_sh_lo  = {1'b0, w_off, 3'b000};
    assign w_sh_hi  = 6'd32 - w_sh_lo;

    always_comb begin
        case (w_size)
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            default: w_size_mask = 8'h0F;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // SECOND relies on the requester holding req_* from the first half.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b1;
        DM_CEB      = 1'b1;
        DM_WEB      = 1'b1;
        DM_A        = w_word;
        DM_DI       = 32'h0;
        w_lanes     = 4'h0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    DM_CEB  = 1'b0;
                    DM_WEB  = ~req_we;
                    w_lanes = w_mask[3:0];
                    DM_DI   = req_wdata << w_sh_lo;
                    if (w_mis) begin
                        req_ready   = 1'b0;
                        w_state_nxt = S_SECOND;
                    end
                end
            end
            S_SECOND: begin
                DM_CEB      = 1'b0;
                DM_WEB      = ~req_we;
                DM_A        = w_word + {{(ADDR_W-1){1'b0}}, 1'b1};
                w_lanes     = w_mask[7:4];
                DM_DI       = req_wdata >> w_sh_hi;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        DM_BWEB = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++)
            DM_BWEB[8*i +: 8] = {8{~(w_lanes[i] & req_we & ~DM_CEB)}};
    end

    assign w_rd_issue = ~DM_CEB & DM_WEB;
    assign w_rsp_fire = r_rd_vld & (~r_rd_split | r_rd_half);

    // Split loads: low word was parked in r_lo_hold, high word arrives now.
    assign w_merge   = r_rd_split ? {DM_DO, r_lo_hold} : {32'h0, DM_DO};
    assign w_shifted = 32'(w_merge >> {r_rd_off, 3'b000});

    always_comb begin
        case (r_rd_size)
            2'b00:   w_ext = {{24{~r_rd_uns & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_ext = {{16{~r_rd_uns & w_shifted[15]}}, w_shifted[15:0]};
            default: w_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld    <= 1'b0;
            r_rd_off    <= 2'b00;
            r_rd_size   <= 2'b00;
            r_rd_uns    <= 1'b0;
            r_rd_split  <= 1'b0;
            r_rd_half   <= 1'b0;
            r_lo_hold   <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_rd_vld    <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_off   <= w_off;
                r_rd_size  <= w_size;
                r_rd_uns   <= req_funct3[2];
                r_rd_split <= (r_state == S_SECOND) | w_mis;
                r_rd_half  <= (r_state == S_SECOND);
            end
            if (r_rd_vld && r_rd_split && !r_rd_half)
                r_lo_hold <= DM_DO;
            r_rsp_valid <= w_rsp_fire;
            if (w_rsp_fire)
                r_rsp_rdata <= w_ext;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_dm_access_port.sv
// Directed bench for dm_access_port with an SRAM model and an in-order
// load-response scoreboard checked against expected data and cycle.
module tb_dm_access_port;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr, req_wdata;
    logic              req_ready, rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              DM_CEB, DM_WEB;
    logic [31:0]       DM_BWEB, DM_DI;
    logic [ADDR_W-1:0] DM_A;
    logic [31:0]       DM_DO;

    always #5 clk = ~clk;

    dm_access_port #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .DM_CEB(DM_CEB), .DM_WEB(DM_WEB), .DM_BWEB(DM_BWEB),
        .DM_A(DM_A), .DM_DI(DM_DI), .DM_DO(DM_DO)
    );

    // SRAM macro model: bit-masked write, registered read
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (!DM_CEB) begin
            if (!DM_WEB) mem[DM_A] <= (mem[DM_A] & DM_BWEB) | (DM_DI & ~DM_BWEB);
            else         DM_DO <= mem[DM_A];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rsp_valid) begin
                vectors++;
                assert (q.size() != 0) else begin
                    errs++;
                    $error("FAIL rsp_unexpected observed=%h expected=no_response", rsp_rdata);
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rsp_data", rsp_rdata, e.data);
                    chk("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (q.size() != 0 && cyc > q[0].due) begin
                vectors++;
                assert (cyc <= q[0].due) else begin
                    errs++;
                    $error("FAIL rsp_timeout observed=cycle_%0d expected=cycle_%0d", cyc, q[0].due);
                end
                void'(q.pop_front());
            end
        end
    end

    task automatic req(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [31:0] d, input int lat);
        q.push_back('{d, cyc + lat});
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        req(1'b1, 1'b1, 3'b010, a, d);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_ceb", {31'b0, DM_CEB}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // aligned word round trip
        req(1'b1, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_ceb", {31'b0, DM_CEB}, 32'd0);
        chk("sw_web", {31'b0, DM_WEB}, 32'd0);
        chk("sw_bweb", DM_BWEB, 32'h0);
        chk("sw_a", 32'(DM_A), 32'h40);
        chk("sw_di", DM_DI, 32'hDEAD_BEEF);
        chk("sw_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        expect_rsp(32'hDEAD_BEEF, 2);
        @(negedge clk);
        chk("lw_web", {31'b0, DM_WEB}, 32'd1);
        chk("lw_bweb", DM_BWEB, 32'hFFFF_FFFF);
        tick();

        // idle pins
        req(1'b0, 1'b1, 3'b010, 32'h104, 32'h1234_5678);
        @(negedge clk);
        chk("idle_ceb", {31'b0, DM_CEB}, 32'd1);
        chk("idle_web", {31'b0, DM_WEB}, 32'd1);
        chk("idle_bweb", DM_BWEB, 32'hFFFF_FFFF);
        chk("idle_di", DM_DI, 32'h0);
        chk("idle_a", 32'(DM_A), 32'h41);
        tick();

        // byte loads and byte store
        sw(32'h200, 32'h8070_6050);
        req(1'b1, 1'b0, 3'b000, 32'h203, 32'h0);
        expect_rsp(32'hFFFF_FF80, 2);
        tick();
        req(1'b1, 1'b0, 3'b100, 32'h203, 32'h0);
        expect_rsp(32'h0000_0080, 2);
        tick();
        req(1'b1, 1'b1, 3'b000, 32'h201, 32'h0000_00AA);
        @(negedge clk);
        chk("sb_bweb", DM_BWEB, 32'hFFFF_00FF);
        chk("sb_di", DM_DI, 32'h0000_AA00);
        tick();
        req(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        expect_rsp(32'h8070_AA50, 2);
        tick();

        // misaligned load
        sw(32'h100, 32'h3322_1100);
        sw(32'h104, 32'h7766_5544);
        req(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        expect_rsp(32'h5544_3322, 3);
        @(negedge clk);
        chk("mlw_ready0", {31'b0, req_ready}, 32'd0);
        chk("mlw_a0", 32'(DM_A), 32'h40);
        tick();
        @(negedge clk);
        chk("mlw_ready1", {31'b0, req_ready}, 32'd1);
        chk("mlw_a1", 32'(DM_A), 32'h41);
        tick();

        // misaligned halfword store
        req(1'b1, 1'b1, 3'b001, 32'h107, 32'h0000_BEEF);
        @(negedge clk);
        chk("msh_a0", 32'(DM_A), 32'h41);
        chk("msh_bweb0", DM_BWEB, 32'h00FF_FFFF);
        chk("msh_di0", DM_DI, 32'hEF00_0000);
        chk("msh_ready0", {31'b0, req_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("msh_a1", 32'(DM_A), 32'h42);
        chk("msh_bweb1", DM_BWEB, 32'hFFFF_FF00);
        chk("msh_di1", DM_DI, 32'h0000_00BE);
        chk("msh_ready1", {31'b0, req_ready}, 32'd1);
        tick();
        req(1'b1, 1'b0, 3'b101, 32'h107, 32'h0);
        expect_rsp(32'h0000_BEEF, 3);
        tick();
        tick();
        req(1'b1, 1'b0, 3'b001, 32'h107, 32'h0);
        expect_rsp(32'hFFFF_BEEF, 3);
        tick();
        tick();
        req(1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
        expect_rsp(32'hEF66_5544, 2);
        tick();

        // high address bits are ignored
        req(1'b1, 1'b0, 3'b010, 32'hFFFF_0100, 32'h0);
        expect_rsp(32'h3322_1100, 2);
        @(negedge clk);
        chk("hiaddr_a", 32'(DM_A), 32'h40);
        tick();

        // wrap-around of the second word
        sw(32'h0000_FFFC, 32'hA1B2_C3D4);
        sw(32'h0000_0000, 32'h1122_3344);
        req(1'b1, 1'b0, 3'b010, 32'h0000_FFFE, 32'h0);
        expect_rsp(32'h3344_A1B2, 3);
        @(negedge clk);
        chk("wrap_a0", 32'(DM_A), 32'h3FFF);
        tick();
        @(negedge clk);
        chk("wrap_a1", 32'(DM_A), 32'h0);
        tick();

        // back-to-back loads
        sw(32'h4, 32'h5566_7788);
        sw(32'h8, 32'h99AA_BBCC);
        req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        expect_rsp(32'h1122_3344, 2);
        tick();
        req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
        expect_rsp(32'h5566_7788, 2);
        tick();
        req(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
        expect_rsp(32'h99AA_BBCC, 2);
        tick();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (6) tick();
        chk("drain_q", 32'(q.size()), 32'd0);

        // reset while in SECOND drops the pending load
        req(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        @(negedge clk);
        chk("rsplit_ready0", {31'b0, req_ready}, 32'd0);
        tick();
        rst = 1'b1;
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("rsplit_ready", {31'b0, req_ready}, 32'd1);
        chk("rsplit_ceb", {31'b0, DM_CEB}, 32'd1);
        chk("rsplit_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rsplit_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
        expect_rsp(32'h5566_7788, 2);
        tick();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (5) tick();
        chk("final_q", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
